gain_ramp_sequencer: RTL and testbench



---
 rtl/gain_ramp_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_gain_ramp_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gain_ramp_sequencer.sv
// Soft-start sequencer: walks the DAC gain code toward a target in bounded steps,
// one SPI-paced update pulse per step. Define GAIN_RAMP_LIMIT_EN to clamp targets below gain_limit.
module gain_ramp_sequencer #(
    parameter logic [15:0] INIT_GAIN   = 16'h0000,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] target_gain,
    input  logic        target_valid,
    input  logic [15:0] step_size,
    input  logic [15:0] step_interval,
    input  logic        abort,
    input  logic        spi_ready,
    input  logic [15:0] gain_limit,
    output logic [15:0] gain_out,
    output logic        gain_update,
    output logic [15:0] current_gain,
    output logic        busy,
    output logic        done,
    output logic        ack_error
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_STEP      = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_INTERVAL  = 3'd5
    } state_t;

    localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] tgt_q, tgt_d;
    logic [15:0] cur_q, cur_d;
    logic [15:0] gain_out_q, gain_out_d;
    logic        gain_update_q, gain_update_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ack_error_q, ack_error_d;
    logic        pend_q, pend_d;
    logic [15:0] cnt_q, cnt_d;

    logic [15:0] tgt_in_s;
    logic [15:0] step_tgt_s;
    logic [15:0] step_eff_s;
    logic [15:0] diff_s;
    logic [15:0] next_s;

`ifdef GAIN_RAMP_LIMIT_EN
    // A code must stay strictly below the limit; a zero limit pins the target to zero.
    function automatic logic [15:0] clamp_target(input logic [15:0] t, input logic [15:0] lim);
        if (lim == 16'h0000) begin
            clamp_target = 16'h0000;
        end else if (t >= lim) begin
            clamp_target = lim - 16'h0001;
        end else begin
            clamp_target = t;
        end
    endfunction

    assign tgt_in_s   = clamp_target(target_gain, gain_limit);
    assign step_tgt_s = clamp_target(tgt_q, gain_limit);
`else
    logic unused_limit_s;
    assign unused_limit_s = ^gain_limit;
    assign tgt_in_s       = target_gain;
    assign step_tgt_s     = tgt_q;
`endif

    // Next step value is derived from the distance so it can never wrap past either end.
    always_comb begin
        step_eff_s = (step_size == 16'h0000) ? 16'h0001 : step_size;
        diff_s     = (step_tgt_s >= cur_q) ? (step_tgt_s - cur_q) : (cur_q - step_tgt_s);
        if (diff_s <= step_eff_s) begin
            next_s = step_tgt_s;
        end else if (step_tgt_s > cur_q) begin
            next_s = cur_q + step_eff_s;
        end else begin
            next_s = cur_q - step_eff_s;
        end
    end

    // Sequencer next-state and output computation.
    always_comb begin
        state_d       = state_q;
        tgt_d         = tgt_q;
        cur_d         = cur_q;
        gain_out_d    = gain_out_q;
        gain_update_d = 1'b0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        ack_error_d   = ack_error_q;
        pend_d        = pend_q;
        cnt_d         = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    pend_d = 1'b0;
                    if (tgt_q == cur_q) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = S_STEP;
                    end
                end else begin
                    pend_d = 1'b0;
                end
            end
            S_STEP: begin
                tgt_d = step_tgt_s;
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (step_tgt_s == cur_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    gain_out_d    = next_s;
                    cur_d         = next_s;
                    gain_update_d = 1'b1;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = 16'h0000;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!spi_ready) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == ACK_LAST) begin
                    ack_error_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'h0001;
                end
            end
            S_WAIT_DONE: begin
                if (!spi_ready) begin
                    state_d = S_WAIT_DONE;
                end else if (cur_q == tgt_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (abort) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = 16'h0000;
                    state_d = S_INTERVAL;
                end
            end
            S_INTERVAL: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (cnt_q >= step_interval) begin
                    state_d = S_STEP;
                end else begin
                    cnt_d = cnt_q + 16'h0001;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // A new target always wins; from IDLE it is evaluated one cycle later.
        if (target_valid) begin
            tgt_d       = tgt_in_s;
            ack_error_d = 1'b0;
            pend_d      = (state_q == S_IDLE);
        end else begin
            tgt_d = tgt_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            tgt_q         <= INIT_GAIN;
            cur_q         <= INIT_GAIN;
            gain_out_q    <= INIT_GAIN;
            gain_update_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ack_error_q   <= 1'b0;
            pend_q        <= 1'b0;
            cnt_q         <= 16'h0000;
        end else begin
            state_q       <= state_d;
            tgt_q         <= tgt_d;
            cur_q         <= cur_d;
            gain_out_q    <= gain_out_d;
            gain_update_q <= gain_update_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            ack_error_q   <= ack_error_d;
            pend_q        <= pend_d;
            cnt_q         <= cnt_d;
        end
    end

    assign gain_out     = gain_out_q;
    assign gain_update  = gain_update_q;
    assign current_gain = cur_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign ack_error    = ack_error_q;

endmodule

// File: tb/tb_gain_ramp_sequencer.sv
// Scoreboard bench for gain_ramp_sequencer: expected gain steps are queued when a target
// is driven and popped on every gain_update pulse; a small SPI model answers each pulse.
module tb_gain_ramp_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] target_gain;
    logic        target_valid;
    logic [15:0] step_size;
    logic [15:0] step_interval;
    logic        abort;
    logic        spi_ready;
    logic [15:0] gain_limit;
    logic [15:0] gain_out;
    logic        gain_update;
    logic [15:0] current_gain;
    logic        busy;
    logic        done;
    logic        ack_error;

    int          checks_total  = 0;
    int          checks_passed = 0;
    int          pulse_cnt     = 0;
    int          done_cnt      = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_val;
    logic [15:0] model_cur;
    logic        spi_hold;

    gain_ramp_sequencer #(.INIT_GAIN(16'h0000), .ACK_TIMEOUT(16)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .target_gain  (target_gain),
        .target_valid (target_valid),
        .step_size    (step_size),
        .step_interval(step_interval),
        .abort        (abort),
        .spi_ready    (spi_ready),
        .gain_limit   (gain_limit),
        .gain_out     (gain_out),
        .gain_update  (gain_update),
        .current_gain (current_gain),
        .busy         (busy),
        .done         (done),
        .ack_error    (ack_error)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_clamp(input logic [15:0] t);
`ifdef GAIN_RAMP_LIMIT_EN
        if (gain_limit == 16'h0000) return 16'h0000;
        else if (t >= gain_limit) return gain_limit - 16'h0001;
        else return t;
`else
        return t;
`endif
    endfunction

    task automatic push_ramp(input logic [15:0] tgt_raw, input logic [15:0] step);
        logic [15:0] t, s, d, n;
        t = model_clamp(tgt_raw);
        s = (step == 16'h0000) ? 16'h0001 : step;
        while (model_cur != t) begin
            d = (t >= model_cur) ? (t - model_cur) : (model_cur - t);
            if (d <= s) n = t;
            else if (t > model_cur) n = model_cur + s;
            else n = model_cur - s;
            exp_q.push_back(n);
            model_cur = n;
        end
    endtask

    task automatic pulse_target(input logic [15:0] tgt);
        @(negedge clk);
        target_gain  = tgt;
        target_valid = 1'b1;
        @(negedge clk);
        target_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_value({tag, "_idle_bound"}, 32'(n < 3000), 32'd1);
    endtask

    task automatic wait_pulses(input string tag, input int count);
        int n;
        n = 0;
        while (pulse_cnt < count && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_value({tag, "_pulse_bound"}, 32'(n < 1000), 32'd1);
    endtask

    task automatic run_ramp(input string tag, input logic [15:0] tgt, input logic [15:0] step,
                            input logic [15:0] interval);
        int d0;
        d0            = done_cnt;
        step_size     = step;
        step_interval = interval;
        push_ramp(tgt, step);
        pulse_target(tgt);
        @(negedge clk);
        check_value({tag, "_busy_rise"}, busy, 1'b1);
        @(negedge clk);
        check_value({tag, "_first_pulse"}, gain_update, 1'b1);
        wait_idle(tag);
        repeat (2) @(negedge clk);
        check_value({tag, "_queue_left"}, exp_q.size(), 32'd0);
        check_value({tag, "_done_count"}, done_cnt - d0, 32'd1);
        check_value({tag, "_final_gain"}, current_gain, model_cur);
    endtask

    // Scoreboard monitor: every update pulse must match the next queued gain code.
    always @(negedge clk) begin
        if (rstn && gain_update) begin
            pulse_cnt++;
            check_value("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_val = exp_q.pop_front();
                check_value("gain_out", gain_out, exp_val);
                check_value("current_gain", current_gain, exp_val);
            end
        end
        if (rstn && done) done_cnt++;
    end

    // Downstream SPI model: ready falls two cycles after a pulse and stays low three cycles.
    initial begin
        spi_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (gain_update && !spi_hold) begin
                repeat (2) @(negedge clk);
                spi_ready = 1'b0;
                repeat (3) @(negedge clk);
                spi_ready = 1'b1;
            end
        end
    end

    initial begin
        int d0, p0, p1, n;
        rstn          = 1'b0;
        target_gain   = 16'h0000;
        target_valid  = 1'b0;
        step_size     = 16'h0001;
        step_interval = 16'h0000;
        abort         = 1'b0;
        gain_limit    = 16'hFFFF;
        spi_hold      = 1'b0;
        model_cur     = 16'h0000;
        repeat (3) @(negedge clk);
        check_value("rst_gain_out", gain_out, 16'h0000);
        check_value("rst_current", current_gain, 16'h0000);
        check_value("rst_flags", {gain_update, busy, done, ack_error}, 4'b0000);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check_value("rst_exit_no_pulse", pulse_cnt, 32'd0);

        run_ramp("ramp_up", 16'h0100, 16'h0040, 16'd4);
        run_ramp("ramp_down", 16'h0010, 16'h0050, 16'd0);
        run_ramp("to_fff0", 16'hFFF0, 16'hFFF0, 16'd1);
        run_ramp("to_ffff", 16'hFFFF, 16'h0100, 16'd1);

        // Target equal to current: no pulse, done one cycle after acceptance.
        d0 = done_cnt;
        p0 = pulse_cnt;
        pulse_target(16'hFFFF);
        @(negedge clk);
        check_value("equal_done", done, 1'b1);
        check_value("equal_busy", busy, 1'b0);
        repeat (5) @(negedge clk);
        check_value("equal_no_pulse", pulse_cnt - p0, 32'd0);
        check_value("equal_done_count", done_cnt - d0, 32'd1);

        run_ramp("step_zero", 16'hFFFD, 16'h0000, 16'd0);
        run_ramp("to_zero", 16'h0000, 16'hFFFF, 16'd2);

        // Retarget after the second pulse reverses the ramp.
        step_size     = 16'h0040;
        step_interval = 16'd2;
        exp_q.push_back(16'h0040);
        exp_q.push_back(16'h0080);
        exp_q.push_back(16'h0040);
        exp_q.push_back(16'h0020);
        d0 = done_cnt;
        p0 = pulse_cnt;
        pulse_target(16'h0200);
        wait_pulses("retarget", p0 + 2);
        pulse_target(16'h0020);
        wait_idle("retarget");
        repeat (2) @(negedge clk);
        check_value("retarget_queue", exp_q.size(), 32'd0);
        check_value("retarget_done", done_cnt - d0, 32'd1);
        check_value("retarget_final", current_gain, 16'h0020);
        model_cur = 16'h0020;

        // Abort while the first write is in flight.
        exp_q.push_back(16'h0060);
        model_cur = 16'h0060;
        d0 = done_cnt;
        p0 = pulse_cnt;
        pulse_target(16'h0220);
        wait_pulses("abort", p0 + 1);
        n = 0;
        while (spi_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_value("abort_spi_bound", 32'(n < 50), 32'd1);
        abort = 1'b1;
        wait_idle("abort");
        abort = 1'b0;
        repeat (20) @(negedge clk);
        check_value("abort_pulses", pulse_cnt - p0, 32'd1);
        check_value("abort_no_done", done_cnt - d0, 32'd0);
        check_value("abort_busy", busy, 1'b0);
        check_value("abort_gain", current_gain, 16'h0060);

        // SPI never acknowledges: sticky ack_error and busy drop.
        spi_hold = 1'b1;
        exp_q.push_back(16'h0080);
        model_cur = 16'h0080;
        d0 = done_cnt;
        p0 = pulse_cnt;
        pulse_target(16'h0080);
        wait_pulses("ack", p0 + 1);
        repeat (8) @(negedge clk);
        check_value("ack_not_early", ack_error, 1'b0);
        check_value("ack_busy_wait", busy, 1'b1);
        n = 0;
        while (!ack_error && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_value("ack_error_set", ack_error, 1'b1);
        check_value("ack_busy_low", busy, 1'b0);
        check_value("ack_no_done", done_cnt - d0, 32'd0);
        spi_hold = 1'b0;
        pulse_target(16'h0080);
        @(negedge clk);
        check_value("ack_cleared", ack_error, 1'b0);
        check_value("ack_equal_done", done, 1'b1);

        // Reset in the middle of a ramp.
        step_size     = 16'h0040;
        step_interval = 16'd4;
        exp_q.push_back(16'h00C0);
        exp_q.push_back(16'h0100);
        p0 = pulse_cnt;
        pulse_target(16'h0400);
        wait_pulses("reset", p0 + 2);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_value("midrst_gain_out", gain_out, 16'h0000);
        check_value("midrst_current", current_gain, 16'h0000);
        check_value("midrst_flags", {gain_update, busy, done, ack_error}, 4'b0000);
        check_value("midrst_queue", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);
        rstn      = 1'b1;
        model_cur = 16'h0000;
        p1        = pulse_cnt;
        repeat (12) @(negedge clk);
        check_value("midrst_no_pulse", pulse_cnt - p1, 32'd0);
        check_value("midrst_idle", busy, 1'b0);

        // Limit clamp (only active when the feature is built in).
        gain_limit = 16'h1072;
        run_ramp("limit", 16'h2000, 16'h0400, 16'd1);
`ifdef GAIN_RAMP_LIMIT_EN
        check_value("limit_end", current_gain, 16'h1071);
`else
        check_value("limit_end", current_gain, 16'h2000);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
